serial_bit_feeder: RTL and testbench
====================================

# serial_bit_feeder

Parallel-in/serial-out feeder that sits directly upstream of the 111-sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and drives them one bit per clock onto the detector's serial input. A one-entry holding buffer lets back-to-back words stream with no idle gap. When no word is being shifted, the serial line is driven to 0 so the detector returns to its no-match state.

## Interface
- WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
- MSB_FIRST, 1, bit order: 1 shifts din[WIDTH-1] first, 0 shifts din[0] first.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDTH  word to serialise; sampled only on an accepting edge.
- load_valid  input  1  producer offers din.
- load_ready  output  1  feeder can accept a word this cycle.
- ser_out  output  1  serial bit; connects to the detector's in port.
- ser_valid  output  1  ser_out carries a data bit this cycle.
- word_done  output  1  high for exactly one cycle, concurrent with the last bit of each word.
- busy  output  1  a word is held or being shifted.

## Operation
- Storage:
  - Holding buffer: hold_data[WIDTH] plus hold_valid.
  - Shifter: shift_reg[WIDTH], bit_cnt of ceil(log2(WIDTH)) bits, and a shifting flag.
- load_ready = !hold_valid && !reset. It is combinational from registered state.
- Accept: a rising edge with load_valid && load_ready. On accept, din is copied to hold_data and hold_valid is set to 1.
- Shifter FSM has two states:
  - IDLE (shifting = 0)
    - If hold_valid = 1: load shift_reg from hold_data, clear hold_valid, set bit_cnt = 0, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT (shifting = 1)
    - Each edge: advance shift_reg by one bit in the MSB_FIRST direction and increment bit_cnt.
    - On the edge where bit_cnt == WIDTH-1, if hold_valid = 1: reload shift_reg from the buffer, clear hold_valid, reset bit_cnt to 0, stay in SHIFT. This gives a seamless join between words.
    - On that edge, if hold_valid = 0: go to IDLE.
- Same-edge accept and buffer drain:
  - An accept requires hold_valid = 0 before the edge, so the buffer can never be loaded and drained on the same edge.
  - A word accepted on the same edge as a reload or return to IDLE waits in the buffer until the next edge.
- Output decoding:
  - ser_out is the current head bit of shift_reg while shifting = 1, and 0 otherwise.
  - ser_valid = shifting.
  - word_done = shifting && bit_cnt == WIDTH-1.
  - busy = shifting || hold_valid.
- Reset (high on an edge) forces shifting = 0, hold_valid = 0, bit_cnt = 0 and shift_reg = 0. Any load_valid in that cycle is ignored.
- Reset mid-word discards the partial word and any buffered word. No word_done is generated for them.

## Timing
- Reset values, in the cycle after a reset edge:
  - ser_out = 0, ser_valid = 0, word_done = 0, busy = 0.
  - load_ready = 1, provided reset is low in that cycle.
- Latency from idle: accept on edge N, then hold_valid = 1 after edge N, then the shifter loads on edge N+1. The first bit is valid in the cycle after edge N+1.
- A word occupies exactly WIDTH consecutive ser_valid cycles. word_done is high in the WIDTH-th of them.
- Back-to-back words: with the buffer full at a word's last bit, the next word's first bit follows in the very next cycle, with no ser_valid gap.
- load_ready drops in the cycle after an accept. It rises again in the cycle after the buffer drains into the shifter.
- Throughput is one word per WIDTH cycles. The producer sees at most one word of slack.

## Test plan
- Single word (WIDTH=8, MSB_FIRST=1): din = 8'b0000_0111 accepted on edge N.
  - ser_out over cycles N+2..N+9 = 0,0,0,0,0,1,1,1 with ser_valid = 1.
  - word_done is high only in cycle N+9; ser_out = 0 and busy = 0 afterwards.
  - The detector output asserts after the third 1.
- LSB_FIRST (MSB_FIRST=0): din = 8'hE0 -> ser_out = 0,0,0,0,0,1,1,1.
- Back-to-back: hold load_valid high with din = 8'hFF, then 8'h00, then 8'hAA.
  - The 24 ser_valid cycles are contiguous, with word_done at bits 8, 16 and 24.
  - load_ready is low whenever the buffer is full; the third word is accepted only after the first drain.
- Backpressure: offer a new word every cycle during a long shift. Exactly one word is accepted per drain, and no word is lost or duplicated; check this against a scoreboard.
- Reset mid-word: assert reset on the 4th bit of 8'hFF with the buffer full.
  - In the next cycle: ser_out = 0, ser_valid = 0, busy = 0, load_ready = 1.
  - No word_done is produced for either word.
- Idle line: no load for 20 cycles -> ser_out = 0, ser_valid = 0 and word_done = 0 in every cycle.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Parallel-in/serial-out feeder: WIDTH-bit words in over valid/ready, one bit per clock out.
// One-entry holding buffer gives seamless word joins; first bit two edges after accept; ready low while buffer full.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    output logic             o_ser_out,
    output logic             o_ser_valid,
    output logic             o_word_done,
    output logic             o_busy
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_hold_data;
    logic             r_hold_valid;
    logic [WIDTH-1:0] r_shift_reg;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] w_shift_adv;
    logic             w_head;
    logic             w_last;
    logic             w_accept;
    logic             w_reload;
    logic             w_advance;

    assign w_last       = (r_bit_cnt == LAST);
    assign o_load_ready = !r_hold_valid && !i_reset;
    assign w_accept     = i_load_valid && o_load_ready;

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shift_adv = {r_shift_reg[WIDTH-2:0], 1'b0};
            assign w_head      = r_shift_reg[WIDTH-1];
        end else begin : g_lsb
            assign w_shift_adv = {1'b0, r_shift_reg[WIDTH-1:1]};
            assign w_head      = r_shift_reg[0];
        end
    endgenerate

    // Reload on the last bit when the buffer is full, so the next word follows with no gap.
    always_comb begin
        w_state_nxt = r_state;
        w_reload    = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_hold_valid) begin
                    w_reload    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last && r_hold_valid) begin
                    w_reload = 1'b1;
                end else begin
                    w_advance = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
            r_shift_reg  <= '0;
            r_bit_cnt    <= '0;
        end else begin
            // Accept needs an empty buffer and a reload needs a full one, so they never coincide.
            if (w_accept) begin
                r_hold_data  <= i_din;
                r_hold_valid <= 1'b1;
            end else if (w_reload) begin
                r_hold_valid <= 1'b0;
            end

            if (w_reload) begin
                r_shift_reg <= r_hold_data;
                r_bit_cnt   <= '0;
            end else if (w_advance) begin
                r_shift_reg <= w_shift_adv;
                r_bit_cnt   <= w_last ? '0 : r_bit_cnt + 1'b1;
            end
        end
    end

    assign o_ser_valid = (r_state == S_SHIFT);
    assign o_ser_out   = o_ser_valid && w_head;
    assign o_word_done = o_ser_valid && w_last;
    assign o_busy      = o_ser_valid || r_hold_valid;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances share stimulus; a word-interval model feeds a bit scoreboard.
module tb_serial_bit_feeder;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       load_valid;

    logic m_ready, m_out, m_vld, m_done, m_busy;
    logic l_ready, l_out, l_vld, l_done, l_busy;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_din        (din),
        .i_load_valid (load_valid),
        .o_load_ready (m_ready),
        .o_ser_out    (m_out),
        .o_ser_valid  (m_vld),
        .o_word_done  (m_done),
        .o_busy       (m_busy)
    );

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_din        (din),
        .i_load_valid (load_valid),
        .o_load_ready (l_ready),
        .o_ser_out    (l_out),
        .o_ser_valid  (l_vld),
        .o_word_done  (l_done),
        .o_busy       (l_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One entry per expected serial bit, tagged with the cycle it must appear in.
    typedef struct {
        int   cyc;
        logic b;
        logic lb;
        logic last;
    } exp_t;

    exp_t q[$];
    int   cyc       = 0;
    int   acc_n     = 0;
    int   acc_start = 0;
    int   last_end  = -1;
    bit   mon_en    = 1'b0;
    int   n_checks  = 0;
    int   n_errors  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit buf_full(input int k);
        return (acc_n <= k) && (k < acc_start);
    endfunction

    // Word accepted on edge n starts at max(n+1, previous word end + 1) and occupies 8 cycles;
    // it sits in the buffer for cycles n .. start-1.
    task automatic model_step();
        int n;
        int s;
        if (reset) begin
            q.delete();
            acc_n     = 0;
            acc_start = 0;
            last_end  = -1;
            mon_en    = 1'b1;
        end else if (mon_en && load_valid && !buf_full(cyc)) begin
            n = cyc + 1;
            s = (n + 1 > last_end + 1) ? n + 1 : last_end + 1;
            for (int i = 0; i < 8; i++) begin
                q.push_back('{s + i, din[7-i], din[i], (i == 7)});
            end
            acc_n     = n;
            acc_start = s;
            last_end  = s + 7;
        end
        cyc++;
    endtask

    task automatic mon_step();
        exp_t e;
        logic ev, eb, elb, el, bf, er;
        ev = 1'b0; eb = 1'b0; elb = 1'b0; el = 1'b0;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            chk("stale_bit_cycle", cyc, q[0].cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e   = q.pop_front();
            ev  = 1'b1;
            eb  = e.b;
            elb = e.lb;
            el  = e.last;
        end
        bf = buf_full(cyc);
        er = !reset && !bf;
        chk("msb_ser_valid",  m_vld,   ev);
        chk("msb_ser_out",    m_out,   eb);
        chk("msb_word_done",  m_done,  el);
        chk("msb_busy",       m_busy,  ev || bf);
        chk("msb_load_ready", m_ready, er);
        chk("lsb_ser_valid",  l_vld,   ev);
        chk("lsb_ser_out",    l_out,   elb);
        chk("lsb_word_done",  l_done,  el);
        chk("lsb_busy",       l_busy,  ev || bf);
        chk("lsb_load_ready", l_ready, er);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (mon_en) mon_step();
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a word valid until accepted; with churn, din changes every refused cycle.
    task automatic drive_word(input logic [7:0] w, input bit churn);
        int   t;
        logic rdy;
        t          = 0;
        rdy        = 1'b0;
        load_valid = 1'b1;
        din        = w;
        while (!rdy && t < 100) begin
            @(negedge clk);
            rdy = m_ready;
            @(posedge clk);
            #1;
            t++;
            if (!rdy && churn) din = 8'($urandom);
        end
        load_valid = 1'b0;
        chk("load_accept_timeout", rdy, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        reset      = 1'b1;
        load_valid = 1'b0;
        din        = 8'h00;
        idle(3);
        reset = 1'b0;
        idle(20);

        drive_word(8'h07, 1'b0);
        idle(14);
        drive_word(8'hE0, 1'b0);
        idle(14);

        drive_word(8'hFF, 1'b0);
        drive_word(8'h00, 1'b0);
        drive_word(8'hAA, 1'b0);
        idle(30);

        drive_word(8'hFF, 1'b0);
        drive_word(8'h5A, 1'b0);
        idle(2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(12);

        for (int i = 0; i < 30; i++) drive_word(8'($urandom), 1'b1);
        idle(12);

        for (int i = 0; i < 40; i++) begin
            idle($urandom_range(0, 3));
            drive_word(8'($urandom), 1'b0);
        end

        w = 0;
        while (q.size() > 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        idle(3);
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
